exe_div: RTL
============

Name: exe_div

Overview:
- Iterative RV32M divide unit inside the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the ID/EX instruction and operands.
- Computes DIV/DIVU/REM/REMU in one bit per cycle.
- Holds the pipeline through a stall request to ctrl until the result is ready, then hands the result to the EX writeback mux.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
op1_i  input  XLEN  dividend (rs1 value from ID/EX)
op2_i  input  XLEN  divisor (rs2 value from ID/EX)
inst_i  input  32  instruction currently in EX (from ID/EX)
flush_jump_i  input  1  branch/jump flush; abort any division
flush_int_i  input  1  interrupt/exception flush; abort any division
stall_other_i  input  1  EX held this cycle by some source other than this block
stall_req_o  output  1  request ctrl to hold IF/ID/EX (drives stall_i[3] path)
result_o  output  XLEN  quotient or remainder, valid only when result_valid_o=1
result_valid_o  output  1  result_o valid this cycle; EX selects it for rd
busy_o  output  1  state != IDLE

Behaviour:
- Decode (combinational): is_div = opcode 0110011, funct7 0000001, funct3[2]=1.
  - funct3 100 = DIV, 101 = DIVU, 110 = REM, 111 = REMU.
  - funct3[0]=1 means unsigned; funct3[1]=1 means remainder.
- States: IDLE, CALC, DONE. Registers: dividend/quotient shift reg, partial remainder (XLEN+1 bits), divisor magnitude, count (clog2(XLEN)+1 bits), neg_q, neg_r, sel_rem, result reg.
- Reset (rst_i=1): state=IDLE, count=0, all datapath regs 0, stall_req_o=0, result_valid_o=0, result_o=0, busy_o=0.
- Flush (flush_jump_i|flush_int_i) in any state: next state IDLE, datapath regs cleared; stall_req_o forced 0 and result_valid_o forced 0 in that same cycle. Reset has priority over flush.
- IDLE:
  - stall_req_o = is_div (combinational, same cycle the instruction enters EX).
  - Divisor == 0: result = all ones (quotient) or op1_i (remainder); next DONE.
  - Signed op with op1_i = 0x80000000 and op2_i = 0xFFFFFFFF: result = 0x80000000 (quotient) or 0 (remainder); next DONE.
  - Otherwise:
    - Latch |op1|, |op2| for signed ops (raw values for unsigned).
    - neg_q = sign(op1) XOR sign(op2) (signed only); neg_r = sign(op1) (signed only).
    - count = XLEN; next CALC.
- CALC:
  - stall_req_o = 1.
  - Each cycle runs one restoring step:
    - rem = {rem[XLEN-1:0], dividend MSB}; dividend shifts left.
    - If rem >= divisor: rem -= divisor and shift 1 into the quotient LSB; else shift 0.
  - count decrements each cycle. On the final step (count==1), load the sign-corrected result (two's complement negate if neg_q/neg_r) into the result reg; next DONE.
- DONE:
  - stall_req_o = 0, result_valid_o = 1, result_o = result reg.
  - If stall_other_i=1: stay in DONE with the result held.
  - Else: next IDLE; the instruction leaves EX this edge.
- Latency:
  - Normal: stall_req_o high for XLEN+1 cycles (IDLE detect + XLEN CALC); result_valid_o on cycle XLEN+2.
  - Special cases: stall 1 cycle, valid on cycle 2.
- The same instruction must not restart. ID/EX advances on the DONE edge, so IDLE sees the next instruction.
- Back-to-back divides: DONE→IDLE, then the next divide is detected immediately. No bubble beyond the pipeline advance.
- Non-divide instructions in IDLE: stall_req_o=0, result_valid_o=0, no state change.
- result_o is 0 whenever result_valid_o=0.

Decomposition:
- Add to defines.v: INST_TYPE_R_M (0110011), FUNCT7_MULDIV (0000001), INST_DIV/DIVU/REM/REMU funct3 codes, DIV_IDLE/DIV_CALC/DIV_DONE state encodings (2 bits).
- Sub-module div_core: a pure iterative unsigned restoring divider (start/done handshake, quotient and remainder outputs).
- exe_div holds decode, sign handling, special cases and the stall protocol.

Test Plan:
- DIV -7 / 2: stall_req_o high 33 cycles; then result_valid_o=1, result_o=0xFFFFFFFD (-3); REM of the same operands gives 0xFFFFFFFF (-1).
- DIVU 0xFFFFFFFF / 0x10: result 0x0FFFFFFF; REMU gives 0xF; exactly 33 stall cycles.
- Divide-by-zero DIV 5/0 gives 0xFFFFFFFF and REM 5/0 gives 5. Overflow DIV 0x80000000 / -1 gives 0x80000000 and REM gives 0. Each: 1 stall cycle, valid on cycle 2.
- flush_jump_i pulsed at CALC cycle 10: the same cycle stall_req_o=0; next cycle state IDLE and busy_o=0. A following ADD sees no stall.
- stall_other_i=1 for 3 cycles in DONE: result_valid_o and result_o held for 4 cycles, then IDLE. Back-to-back DIVU 100/7 then REMU 100/7 give 14 then 2 with no extra bubble.
- rst_i asserted mid-CALC: next edge all outputs 0, state IDLE. A new DIV after reset computes correctly.

Source files
------------

// File: rtl/exe_div_pkg.sv
// exe_div_pkg: shared encodings and decode helper for the execute-stage divider.
//   - R-type M-extension opcode/funct7, the four divide funct3 codes
//   - divider FSM state encoding (2 bits)
//   - div_decode(): classifies an instruction as DIV/DIVU/REM/REMU
package exe_div_pkg;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    typedef struct packed {
        logic is_div;
        logic is_unsigned;
        logic is_rem;
    } div_dec_t;

    function automatic div_dec_t div_decode(input logic [31:0] inst);
        div_dec_t   d;
        logic [2:0] f3;
        f3            = inst[14:12];
        d.is_div      = (inst[6:0] == INST_TYPE_R_M) && (inst[31:25] == FUNCT7_MULDIV) &&
                        ((f3 == INST_DIV) || (f3 == INST_DIVU) ||
                         (f3 == INST_REM) || (f3 == INST_REMU));
        d.is_unsigned = (f3 == INST_DIVU) || (f3 == INST_REMU);
        d.is_rem      = (f3 == INST_REM)  || (f3 == INST_REMU);
        return d;
    endfunction

endpackage

// File: rtl/exe_div_core.sv
// div_core: iterative unsigned restoring divider, one quotient bit per cycle.
//   clk_i, rst_i     clock / synchronous active-high reset
//   clear_i          abort: clears all state (pipeline flush)
//   start_i          load dividend/divisor and begin XLEN steps
//   dividend_i       unsigned dividend
//   divisor_i        unsigned divisor (nonzero; zero is handled upstream)
//   last_o           the step executing this cycle is the final one
//   quot_o, rem_o    quotient / remainder after this cycle's step
//                    (final values when last_o=1)
module div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            last_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    // Dividend shifts out of the MSB while quotient bits shift in at the LSB.
    logic [XLEN-1:0]  dvd_q;
    logic [XLEN:0]    rem_q;
    logic [XLEN-1:0]  dvs_q;
    logic [CNT_W-1:0] cnt_q;

    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    rem_n;
    logic [XLEN-1:0]  dvd_n;
    logic             ge;

    always_comb begin
        // The remainder's top bit is always 0 between steps, so shifting the
        // full register left loses nothing.
        rem_sh = (rem_q << 1) | {{XLEN{1'b0}}, dvd_q[XLEN-1]};
        ge     = rem_sh >= {1'b0, dvs_q};
        rem_n  = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        dvd_n  = {dvd_q[XLEN-2:0], ge};
    end

    assign last_o = (cnt_q == CNT_W'(1));
    assign quot_o = dvd_n;
    assign rem_o  = rem_n[XLEN-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            dvd_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            dvd_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
            cnt_q <= CNT_W'(XLEN);
        end else if (cnt_q != '0) begin
            dvd_q <= dvd_n;
            rem_q <= rem_n;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/exe_div.sv
// exe_div: RV32M DIV/DIVU/REM/REMU unit in the execute stage.
//   clk_i, rst_i       clock / synchronous active-high reset
//   op1_i, op2_i       dividend / divisor from ID/EX
//   inst_i             instruction currently in EX
//   flush_jump_i       branch/jump flush, aborts a division
//   flush_int_i        interrupt/exception flush, aborts a division
//   stall_other_i      EX held this cycle by another source
//   stall_req_o        hold IF/ID/EX while the divide is in progress
//   result_o           quotient/remainder, zero unless result_valid_o
//   result_valid_o     EX writeback should select result_o
//   busy_o             FSM not idle
module exe_div
    import exe_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [31:0]     inst_i,
    input  logic            flush_jump_i,
    input  logic            flush_int_i,
    input  logic            stall_other_i,
    output logic            stall_req_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output logic            busy_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    div_dec_t        dec;
    logic            flush;
    logic            op1_neg, op2_neg;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, ovf, special;
    logic [XLEN-1:0] special_res;
    logic            core_start, core_last;
    logic [XLEN-1:0] core_quot, core_rem;
    logic [XLEN-1:0] fixed_res;

    logic            neg_q, neg_r, sel_rem;
    logic [XLEN-1:0] result_q;

    assign flush = flush_jump_i | flush_int_i;
    assign dec   = div_decode(inst_i);

    always_comb begin
        op1_neg  = !dec.is_unsigned && op1_i[XLEN-1];
        op2_neg  = !dec.is_unsigned && op2_i[XLEN-1];
        mag1     = op1_neg ? -op1_i : op1_i;
        mag2     = op2_neg ? -op2_i : op2_i;
        div_zero = (op2_i == '0);
        ovf      = !dec.is_unsigned && (op1_i == MIN_NEG) && (op2_i == '1);
        special  = div_zero || ovf;
        if (div_zero) special_res = dec.is_rem ? op1_i : '1;
        else          special_res = dec.is_rem ? '0 : MIN_NEG;
    end

    // Only ordinary divides go through the iterative core; the two special
    // cases complete straight from IDLE.
    assign core_start = (state_q == DIV_IDLE) && dec.is_div && !special && !flush;

    div_core #(.XLEN(XLEN)) u_core (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (flush),
        .start_i    (core_start),
        .dividend_i (mag1),
        .divisor_i  (mag2),
        .last_o     (core_last),
        .quot_o     (core_quot),
        .rem_o      (core_rem)
    );

    assign fixed_res = sel_rem ? (neg_r ? -core_rem  : core_rem)
                               : (neg_q ? -core_quot : core_quot);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= DIV_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: if (dec.is_div) state_d = special ? DIV_DONE : DIV_CALC;
                DIV_CALC: if (core_last) state_d = DIV_DONE;
                // ID/EX advances on this edge, so IDLE never sees the same
                // divide twice.
                DIV_DONE: if (!stall_other_i) state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        stall_req_o    = 1'b0;
        result_valid_o = 1'b0;
        if (!rst_i && !flush) begin
            case (state_q)
                DIV_IDLE: stall_req_o    = dec.is_div;
                DIV_CALC: stall_req_o    = 1'b1;
                DIV_DONE: result_valid_o = 1'b1;
                default:  ;
            endcase
        end
        result_o = result_valid_o ? result_q : '0;
        busy_o   = (state_q != DIV_IDLE);
    end

    // Sign flags and result register
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            sel_rem  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (dec.is_div) begin
                        sel_rem <= dec.is_rem;
                        neg_q   <= op1_neg ^ op2_neg;
                        neg_r   <= op1_neg;
                        if (special) result_q <= special_res;
                    end
                end
                DIV_CALC: if (core_last) result_q <= fixed_res;
                default:  ;
            endcase
        end
    end

endmodule
